// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: N valid/ready requesters share one downstream port, locked per burst.
// Optional burst-length cap enabled by defining ARB_BURST_LIMIT_EN (caps bursts at MAX_BEATS beats).
module rr_burst_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 32,
  parameter int MAX_BEATS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_valid_i,
  input  logic [N*DW-1:0]      req_data_i,
  input  logic [N-1:0]         req_last_i,
  output logic [N-1:0]         req_ready_o,
  output logic                 out_valid_o,
  output logic [DW-1:0]        out_data_o,
  output logic                 out_last_o,
  output logic [$clog2(N)-1:0] out_id_o,
  input  logic                 out_ready_i,
  output logic [N-1:0]         gnt_o,
  output logic                 busy_o
);

  localparam int IW = $clog2(N);

  if (N < 2 || MAX_BEATS < 1) begin : g_param_check
    $error("rr_burst_arbiter: N must be >= 2 and MAX_BEATS >= 1");
  end

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state_q;
  logic [N-1:0]  mask_q;
  logic [N-1:0]  gnt_q;
  logic [IW-1:0] id_q;

  logic [N-1:0]  masked_req;
  logic [N-1:0]  mask_above;
  logic [IW-1:0] win_id;
  logic [DW-1:0] data_arr [N];
  logic          limit_hit;
  logic          beat;

  assign masked_req = req_valid_i & mask_q;

  // Lowest index of the masked set, falling back to the lowest valid requester.
  always_comb begin
    win_id = '0;
    if (|masked_req) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (masked_req[i]) win_id = IW'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req_valid_i[i]) win_id = IW'(i);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign data_arr[gi]    = req_data_i[gi*DW +: DW];
    assign mask_above[gi]  = (IW'(gi) > id_q);
    assign req_ready_o[gi] = busy_o & gnt_q[gi] & out_ready_i;
  end

`ifdef ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BEATS + 1);
  logic [CW-1:0] beat_cnt_q;
  assign limit_hit = (beat_cnt_q == CW'(MAX_BEATS - 1));
`else
  assign limit_hit = 1'b0;
`endif

  assign busy_o      = (state_q == BURST);
  assign gnt_o       = gnt_q;
  assign out_id_o    = id_q;
  assign out_valid_o = busy_o & req_valid_i[id_q];
  assign out_last_o  = busy_o & (req_last_i[id_q] | limit_hit);
  assign out_data_o  = busy_o ? data_arr[id_q] : '0;
  assign beat        = out_valid_o & out_ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mask_q     <= '1;
      gnt_q      <= '0;
      id_q       <= '0;
`ifdef ARB_BURST_LIMIT_EN
      beat_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid_i) begin
            state_q <= BURST;
            gnt_q   <= N'(1) << win_id;
            id_q    <= win_id;
          end
        end
        BURST: begin
          if (beat) begin
            if (out_last_o) begin
              // Pointer moves past the owner; id is cleared so it reads 0 while idle.
              state_q    <= IDLE;
              gnt_q      <= '0;
              id_q       <= '0;
              mask_q     <= mask_above;
`ifdef ARB_BURST_LIMIT_EN
              beat_cnt_q <= '0;
`endif
            end else begin
`ifdef ARB_BURST_LIMIT_EN
              beat_cnt_q <= beat_cnt_q + 1'b1;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench for rr_burst_arbiter: directed scenarios plus random traffic,
// compared each cycle against a circular-scan round-robin reference model.
module tb_rr_burst_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int IW = $clog2(N);
  localparam int W  = N + 3 + IW + N + DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [IW-1:0] out_id;
  logic          out_ready = 1'b1;
  logic [N-1:0]  gnt;
  logic          busy;
  logic [W-1:0]  obs;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // requester stimulus state
  int rem  [N];
  int bnum [N];
  bit hold [N];
  bit refill = 1'b0;

  // reference model state
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cnt;

  rr_burst_arbiter #(.N(N), .DW(DW), .MAX_BEATS(MB)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last),
    .out_id_o(out_id), .out_ready_i(out_ready),
    .gnt_o(gnt), .busy_o(busy)
  );

  always #5 clk = ~clk;

  assign obs = {gnt, busy, out_valid, out_last, out_id, req_ready, out_data};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [DW-1:0] beat_data(int i, int b);
    return {8'(i), 24'(b)};
  endfunction

  function automatic int pick();
    for (int s = 1; s <= N; s++) begin
      int j;
      j = (m_ptr + s) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] exp_obs();
    logic [N-1:0]  eg, er;
    logic          ev, el;
    logic [IW-1:0] eid;
    logic [DW-1:0] ed;
    eg = '0; er = '0; ev = 1'b0; el = 1'b0; eid = '0; ed = '0;
    if (m_busy) begin
      eg[m_owner] = 1'b1;
      ev = req_valid[m_owner];
      el = req_last[m_owner];
`ifdef ARB_BURST_LIMIT_EN
      if (m_cnt == MB - 1) el = 1'b1;
`endif
      er[m_owner] = out_ready;
      eid = IW'(m_owner);
      ed = req_data[m_owner*DW +: DW];
    end
    return {eg, m_busy, ev, el, eid, er, ed};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (rem[i] > 0) && !hold[i];
      req_last[i]  = (rem[i] == 1);
      req_data[i*DW +: DW] = beat_data(i, bnum[i]);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_ptr = N - 1; m_cnt = 0;
  endtask

  // Advance one clock, updating the model from the inputs held across the edge.
  task automatic tick();
    int p;
    bit end_burst;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (m_busy) begin
      if (req_valid[m_owner] && out_ready) begin
        end_burst = req_last[m_owner];
        rem[m_owner]--;
        bnum[m_owner]++;
        m_cnt++;
`ifdef ARB_BURST_LIMIT_EN
        if (m_cnt == MB) end_burst = 1'b1;
`endif
        if (refill && rem[m_owner] == 0) rem[m_owner] = 1;
        if (end_burst) begin
          m_ptr = m_owner; m_busy = 1'b0; m_cnt = 0;
        end
      end
    end else begin
      p = pick();
      if (p >= 0) begin
        m_busy = 1'b1; m_owner = p; m_cnt = 0;
      end
    end
    @(negedge clk);
    drive();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; bnum[i] = 0; hold[i] = 1'b0;
    end
    refill = 1'b0;
    out_ready = 1'b1;
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    chk_cnt++;
    if (obs !== '0) $display("FAIL reset_state obs=%h exp=0", obs);
    else pass_cnt++;
  endtask

  task automatic test_single_requester();
    apply_reset();
    rem[2] = 3;
    drive();
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        rem[0] = 1; rem[3] = 1; drive();
      end
      #1;
      chk_cnt++;
      if (obs !== exp_obs()) $display("FAIL single c%0d obs=%h exp=%h", c, obs, exp_obs());
      else pass_cnt++;
      if (c == 1) begin
        chk_cnt++;
        if (gnt !== 4'b0100 || out_id !== 2'd2)
          $display("FAIL single_grant gnt=%b id=%0d exp gnt=0100 id=2", gnt, out_id);
        else pass_cnt++;
      end
      if (c >= 1 && c <= 3) begin
        chk_cnt++;
        if (out_data !== beat_data(2, c - 1) || out_valid !== 1'b1)
          $display("FAIL single_data c%0d data=%h exp=%h", c, out_data, beat_data(2, c - 1));
        else pass_cnt++;
      end
      if (c == 4) begin
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL single_idle_gap busy=%b exp=0", busy);
        else pass_cnt++;
      end
      if (c == 5) begin
        chk_cnt++;
        if (gnt !== 4'b1000) $display("FAIL single_mask_next gnt=%b exp=1000", gnt);
        else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] eg;
    apply_reset();
    refill = 1'b1;
    for (int i = 0; i < N; i++) rem[i] = 1;
    drive();
    for (int c = 0; c < 12; c++) begin
      #1;
      chk_cnt++;
      if (obs !== exp_obs()) $display("FAIL rotation c%0d obs=%h exp=%h", c, obs, exp_obs());
      else pass_cnt++;
      eg = (c % 2 == 1) ? (N'(1) << ((c / 2) % N)) : '0;
      chk_cnt++;
      if (gnt !== eg || busy !== 1'(c % 2))
        $display("FAIL rotation_order c%0d gnt=%b busy=%b exp gnt=%b", c, gnt, busy, eg);
      else pass_cnt++;
      tick();
    end
    refill = 1'b0;
  endtask

  task automatic test_burst_lock();
    apply_reset();
    rem[1] = 5;
    drive();
    for (int c = 0; c < 13; c++) begin
      if (c == 2) rem[0] = 2;
      hold[1] = (c >= 2 && c <= 4);
      drive();
      #1;
      chk_cnt++;
      if (obs !== exp_obs()) $display("FAIL lock c%0d obs=%h exp=%h", c, obs, exp_obs());
      else pass_cnt++;
      if (c >= 2 && c <= 4) begin
        chk_cnt++;
        if (gnt !== 4'b0010 || req_ready[0] !== 1'b0 || out_valid !== 1'b0)
          $display("FAIL lock_hold c%0d gnt=%b rdy0=%b vld=%b exp 0010/0/0", c, gnt, req_ready[0], out_valid);
        else pass_cnt++;
      end
      if (c == 8) begin
        chk_cnt++;
        if (out_last !== 1'b1 || gnt !== 4'b0010)
          $display("FAIL lock_last last=%b gnt=%b exp 1/0010", out_last, gnt);
        else pass_cnt++;
      end
      if (c == 10) begin
        chk_cnt++;
        if (gnt !== 4'b0001) $display("FAIL lock_next gnt=%b exp=0001", gnt);
        else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    rem[3] = 4;
    drive();
    for (int c = 0; c < 11; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      #1;
      chk_cnt++;
      if (obs !== exp_obs()) $display("FAIL backpressure c%0d obs=%h exp=%h", c, obs, exp_obs());
      else pass_cnt++;
      if (c >= 3 && c <= 6) begin
        chk_cnt++;
        if (req_ready !== '0 || out_data !== beat_data(3, 2))
          $display("FAIL bp_stall c%0d rdy=%b data=%h exp 0000/%h", c, req_ready, out_data, beat_data(3, 2));
        else pass_cnt++;
      end
      tick();
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    rem[3] = 3;
    drive();
    for (int c = 0; c < 2; c++) begin
      if (c == 1) begin
        rem[1] = 2; drive();
      end
      #1;
      chk_cnt++;
      if (obs !== exp_obs()) $display("FAIL rstmid c%0d obs=%h exp=%h", c, obs, exp_obs());
      else pass_cnt++;
      tick();
    end
    #1;
    reset = 1'b1;
    #1;
    chk_cnt++;
    if (gnt !== '0 || busy !== 1'b0 || out_valid !== 1'b0 || req_ready !== '0)
      $display("FAIL rstmid_drop gnt=%b busy=%b vld=%b rdy=%b exp all 0", gnt, busy, out_valid, req_ready);
    else pass_cnt++;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk_cnt++;
      if (obs !== exp_obs()) $display("FAIL rstmid_after c%0d obs=%h exp=%h", c, obs, exp_obs());
      else pass_cnt++;
      if (c == 1) begin
        chk_cnt++;
        if (gnt !== 4'b0010) $display("FAIL rstmid_regrant gnt=%b exp=0010", gnt);
        else pass_cnt++;
      end
      tick();
    end
  endtask

`ifdef ARB_BURST_LIMIT_EN
  task automatic test_burst_limit();
    apply_reset();
    rem[0] = 6; rem[1] = 2;
    drive();
    for (int c = 0; c < 12; c++) begin
      #1;
      chk_cnt++;
      if (obs !== exp_obs()) $display("FAIL limit c%0d obs=%h exp=%h", c, obs, exp_obs());
      else pass_cnt++;
      if (c == 4) begin
        chk_cnt++;
        if (out_last !== 1'b1 || gnt !== 4'b0001)
          $display("FAIL limit_forced_last last=%b gnt=%b exp 1/0001", out_last, gnt);
        else pass_cnt++;
      end
      if (c == 6) begin
        chk_cnt++;
        if (gnt !== 4'b0010) $display("FAIL limit_next gnt=%b exp=0010", gnt);
        else pass_cnt++;
      end
      if (c == 9 || c == 10) begin
        chk_cnt++;
        if (gnt !== 4'b0001 || out_data !== beat_data(0, c - 5))
          $display("FAIL limit_tail c%0d gnt=%b data=%h exp 0001/%h", c, gnt, out_data, beat_data(0, c - 5));
        else pass_cnt++;
      end
      tick();
    end
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && ($urandom % 4) == 0) rem[i] = $urandom_range(1, 6);
        hold[i] = (($urandom % 5) == 0);
      end
      out_ready = (($urandom % 4) != 0);
      drive();
      #1;
      chk_cnt++;
      if (obs !== exp_obs()) $display("FAIL random c%0d obs=%h exp=%h", c, obs, exp_obs());
      else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; bnum[i] = 0; hold[i] = 1'b0;
    end
    model_reset();
    test_reset();
    test_single_requester();
    test_rotation();
    test_burst_lock();
    test_backpressure();
    test_reset_mid_burst();
`ifdef ARB_BURST_LIMIT_EN
    test_burst_limit();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Round-robin burst arbiter that shares one downstream valid/ready data port between N requesters. A requester wins the port and keeps it for a whole burst, from its first beat to its `last` beat. The round-robin pointer then moves past the winner. The block sits in front of any shared single-port resource (memory port, bus master) and reuses the masked/unmasked fixed-priority round-robin policy of the 4-way arbiter, with burst locking and a registered grant added.

## Interface
Parameters:
- `N`, default 4: number of requesters, ≥2.
- `DW`, default 32: data width per beat.
- `MAX_BEATS`, default 8: burst cap. Only used when `ARB_BURST_LIMIT_EN` is defined.

Ports (name, direction, width, meaning):
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid_i` in N: per-requester beat valid.
- `req_data_i` in N*DW: requester i occupies bits [i*DW +: DW].
- `req_last_i` in N: final beat of the requester's burst.
- `req_ready_o` out N: beat accepted from requester i.
- `out_valid_o` out 1: downstream beat valid.
- `out_data_o` out DW: downstream data.
- `out_last_o` out 1: downstream last beat.
- `out_id_o` out $clog2(N): index of the current owner.
- `out_ready_i` in 1: downstream ready.
- `gnt_o` out N: one-hot registered owner, zero when idle.
- `busy_o` out 1: the state is BURST.

## Operation
- State machine with two states, IDLE and BURST.
- IDLE:
  - If `|req_valid_i` is 1, pick a winner.
  - Winner is the lowest-index requester in `req_valid_i & mask_q`. If that set is empty, it is the lowest-index requester in `req_valid_i`.
  - Register the winner into `gnt_o`/`out_id_o` and go to BURST.
  - If no requester is valid, stay in IDLE.
- BURST, combinational path from owner k:
  - `out_valid_o = req_valid_i[k]`
  - `out_data_o = req_data_i[k]`
  - `out_last_o = req_last_i[k]`
  - `req_ready_o[k] = out_ready_i`
  - `req_ready_o` is 0 for every other requester.
- Beat: `out_valid_o & out_ready_i`.
- On a beat with `out_last_o = 1`:
  - Clear `gnt_o`.
  - Set `mask_q` to ones strictly above k (k=N-1 gives all zeros).
  - Go to IDLE.
- Owner deasserts valid mid-burst: the grant is held, `out_valid_o` = 0, and no other requester is served.
- Outside BURST: `out_valid_o`, `out_last_o` and `req_ready_o` are 0, and `out_data_o` and `out_id_o` are don't-care (drive 0).
- Reset values: state IDLE, `mask_q` all ones, `gnt_o` 0, `busy_o` 0, `out_id_o` 0, beat counter 0.

## Timing
- Arbitration latency is one cycle. Valid is first seen in IDLE at cycle t, `gnt_o`/`busy_o` assert at t+1, and the first beat can complete at t+1.
- Data path: zero-latency combinational mux from owner to output. There is no internal buffering.
- Minimum gap between bursts is one IDLE cycle. Peak throughput for bursts of L beats is L/(L+1).
- A single-beat burst (`last` on the first beat) occupies exactly one BURST cycle.
- A last beat and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle using the updated `mask_q`.
- Reset asserted mid-burst: immediately drops to IDLE and outputs go to reset values. The interrupted beat is not completed.

## Configuration
- `ARB_BURST_LIMIT_EN` defined:
  - A beat counter of width $clog2(MAX_BEATS+1) increments on each beat and clears on entry to IDLE.
  - On the MAX_BEATS-th beat, `out_last_o` is forced to 1 and the burst ends as on a natural last beat. The pointer advances normally.
  - The requester's remaining beats form a new burst and re-arbitrate.
- `ARB_BURST_LIMIT_EN` undefined: no counter. Bursts are unbounded, and `out_last_o` equals `req_last_i[k]`.

## Test plan
- **Single requester:** after reset, req 2 sends 3 beats (last on the 3rd) with `out_ready_i`=1.
  - `gnt_o`=0100 one cycle after valid.
  - Data passes in order, `out_id_o`=2.
  - `mask_q`=1000, followed by one IDLE cycle.
- **Rotation:** all 4 requesters continuously send 1-beat bursts.
  - Grant order is 0,1,2,3,0,1.
  - Each burst is separated by one IDLE cycle.
- **Burst lock:** owner 1 deasserts valid for 3 cycles mid-burst while req 0 is valid.
  - `gnt_o` stays 0010 and `req_ready_o[0]` stays 0.
  - Burst resumes and completes on 1's last beat.
- **Backpressure:** `out_ready_i`=0 for 4 cycles mid-burst.
  - `req_ready_o[k]`=0, data is held stable by the requester, and no beat is counted.
- **Reset mid-burst:** assert reset during the 2nd beat.
  - `gnt_o`=0, `busy_o`=0 and `out_valid_o`=0 immediately.
  - The next grant after release is the lowest valid index.
- **Burst limit (`ARB_BURST_LIMIT_EN`, MAX_BEATS=4):** req 0 sends 6 beats with last on the 6th, and req 1 is also valid.
  - Beat 4 has `out_last_o`=1.
  - Req 1 is granted next, then req 0 delivers its remaining 2 beats.
